// File: rtl/pacote_iluminacao.sv
// Shared definitions for the lighting command generator: FSM state types and
// default timing parameters.
package pacote_iluminacao;

    localparam int unsigned DEB_CYCLES_PADRAO  = 50000;
    localparam int unsigned LONG_CYCLES_PADRAO = 1500000;
    localparam int unsigned OFF_CYCLES_PADRAO  = 3000000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_SENT = 2'd2
    } estado_botao_t;

    typedef enum logic [1:0] {
        VAZIO    = 2'd0,
        OCUPADO  = 2'd1,
        CONTANDO = 2'd2
    } estado_presenca_t;

endpackage

// File: rtl/filtro_debounce.sv
// Two-flop synchronizer followed by a debouncer: the filtered level changes only
// after the synchronized input has disagreed with it for DEB_CYCLES cycles in a row.
module filtro_debounce #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic entrada,
    output logic nivel
);

    localparam int unsigned W      = $clog2(DEB_CYCLES + 1);
    localparam logic [W-1:0] LIMITE = W'(DEB_CYCLES - 1);
    localparam logic [W-1:0] MAXIMO = W'(DEB_CYCLES);

    logic         s0;
    logic         s1;
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            cnt   <= '0;
            nivel <= 1'b0;
        end else begin
            s0 <= entrada;
            s1 <= s0;
            if (s1 == nivel) begin
                cnt <= '0;
            end else if (cnt >= LIMITE) begin
                nivel <= s1;
                cnt   <= '0;
            end else if (cnt != MAXIMO) begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/gerador_comandos.sv
// Turns a bouncing push button and a presence sensor into one-cycle command pulses:
// a = mode toggle (long press), b = lamp toggle (short press), c = auto-off, d = auto-on.
module gerador_comandos
    import pacote_iluminacao::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_PADRAO,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_PADRAO,
    parameter int unsigned OFF_CYCLES  = OFF_CYCLES_PADRAO
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    input  logic presenca,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    localparam int unsigned WL = $clog2(LONG_CYCLES + 1);
    localparam int unsigned WO = $clog2(OFF_CYCLES + 1);
    localparam logic [WL-1:0] LONG_LIM = WL'(LONG_CYCLES - 1);
    localparam logic [WL-1:0] LONG_MAX = WL'(LONG_CYCLES);
    localparam logic [WO-1:0] OFF_LIM  = WO'(OFF_CYCLES - 1);
    localparam logic [WO-1:0] OFF_MAX  = WO'(OFF_CYCLES);

    logic deb_botao;
    logic deb_presenca;

    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_botao (
        .clk(clk), .rst(rst), .entrada(botao), .nivel(deb_botao)
    );

    filtro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_presenca (
        .clk(clk), .rst(rst), .entrada(presenca), .nivel(deb_presenca)
    );

    estado_botao_t    estado_b, estado_b_prox;
    estado_presenca_t estado_p, estado_p_prox;
    logic [WL-1:0]    hold_cnt;
    logic [WO-1:0]    off_cnt;
    logic             a_prox, b_prox, c_prox, d_prox;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_b <= IDLE;
            estado_p <= VAZIO;
            a        <= 1'b0;
            b        <= 1'b0;
            c        <= 1'b0;
            d        <= 1'b0;
        end else begin
            estado_b <= estado_b_prox;
            estado_p <= estado_p_prox;
            a        <= a_prox;
            b        <= b_prox;
            c        <= c_prox;
            d        <= d_prox;
        end
    end

    // Counters run only inside their timing state, so entering it always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            off_cnt  <= '0;
        end else begin
            if (estado_b != PRESSED)
                hold_cnt <= '0;
            else if (hold_cnt != LONG_MAX)
                hold_cnt <= hold_cnt + WL'(1);

            if (estado_p != CONTANDO)
                off_cnt <= '0;
            else if (off_cnt != OFF_MAX)
                off_cnt <= off_cnt + WO'(1);
        end
    end

    always_comb begin
        estado_b_prox = estado_b;
        a_prox        = 1'b0;
        b_prox        = 1'b0;
        case (estado_b)
            IDLE: begin
                if (deb_botao)
                    estado_b_prox = PRESSED;
            end
            PRESSED: begin
                if (!deb_botao) begin
                    b_prox        = 1'b1;
                    estado_b_prox = IDLE;
                end else if (hold_cnt == LONG_LIM) begin
                    a_prox        = 1'b1;
                    estado_b_prox = LONG_SENT;
                end
            end
            LONG_SENT: begin
                if (!deb_botao)
                    estado_b_prox = IDLE;
            end
            default: estado_b_prox = IDLE;
        endcase
    end

    always_comb begin
        estado_p_prox = estado_p;
        c_prox        = 1'b0;
        d_prox        = 1'b0;
        case (estado_p)
            VAZIO: begin
                if (deb_presenca) begin
                    d_prox        = 1'b1;
                    estado_p_prox = OCUPADO;
                end
            end
            OCUPADO: begin
                if (!deb_presenca)
                    estado_p_prox = CONTANDO;
            end
            CONTANDO: begin
                if (deb_presenca) begin
                    estado_p_prox = OCUPADO;
                end else if (off_cnt == OFF_LIM) begin
                    c_prox        = 1'b1;
                    estado_p_prox = VAZIO;
                end
            end
            default: estado_p_prox = VAZIO;
        endcase
    end

endmodule

// File: tb/tb_gerador_comandos.sv
// Bench for gerador_comandos: a behavioural model predicts the cycle of every pulse,
// and a separate monitor pops and compares those predictions as pulses appear.
module tb_gerador_comandos;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned OFF  = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic botao = 1'b0;
    logic presenca = 1'b0;
    logic a, b, c, d;

    gerador_comandos #(
        .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .OFF_CYCLES(OFF)
    ) dut (
        .clk(clk), .rst(rst), .botao(botao), .presenca(presenca),
        .a(a), .b(b), .c(c), .d(d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // expected pulse cycles per output: 0=a 1=b 2=c 3=d
    int expq[4][$];
    int pulse_cnt[4];
    int last_cyc[4];

    // reference model: 0=button 1=presence
    logic win[2][$];
    logic deb_m[2];
    logic p0[2];
    logic p1[2];
    int   high_run = 0;
    int   low_run = 0;
    bit   occupied = 0;
    logic old_b, old_p, nb, np;

    initial begin
        for (int i = 0; i < 2; i++) begin
            deb_m[i] = 1'b0; p0[i] = 1'b0; p1[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            pulse_cnt[i] = 0; last_cyc[i] = 0;
        end
    end

    // Level seen by the filter is the raw value from two edges ago; it flips once
    // the last DEB such samples all disagree with the current filtered level.
    function automatic logic step_deb(input int i, input logic raw);
        bit all_diff;
        win[i].push_back(p1[i]);
        if (win[i].size() > int'(DEB)) void'(win[i].pop_front());
        p1[i] = p0[i];
        p0[i] = raw;
        all_diff = (win[i].size() == int'(DEB));
        for (int k = 0; k < win[i].size(); k++)
            if (win[i][k] == deb_m[i]) all_diff = 0;
        if (all_diff) deb_m[i] = ~deb_m[i];
        return deb_m[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                win[i].delete();
                deb_m[i] = 1'b0; p0[i] = 1'b0; p1[i] = 1'b0;
            end
            for (int i = 0; i < 4; i++) expq[i].delete();
            high_run = 0;
            low_run  = 0;
            occupied = 0;
        end else begin
            cyc++;
            old_b = deb_m[0];
            old_p = deb_m[1];
            nb = step_deb(0, botao);
            np = step_deb(1, presenca);
            // press: long once held LONG+1 filtered cycles, short if released sooner
            if (nb) begin
                high_run++;
                if (high_run == int'(LONG) + 1) expq[0].push_back(cyc + 1);
            end else begin
                if (old_b && high_run <= int'(LONG)) expq[1].push_back(cyc + 1);
                high_run = 0;
            end
            // presence: on when first seen, off after OFF+1 filtered cycles of absence
            if (np) begin
                low_run = 0;
                if (!old_p && !occupied) begin
                    expq[3].push_back(cyc + 1);
                    occupied = 1;
                end
            end else if (occupied) begin
                low_run++;
                if (low_run == int'(OFF) + 1) begin
                    expq[2].push_back(cyc + 1);
                    occupied = 0;
                    low_run  = 0;
                end
            end
        end
    end

    task automatic port_chk(input int i, input string nm, input logic v);
        int e;
        if (v) begin
            pulse_cnt[i]++;
            last_cyc[i] = cyc;
            checks++;
            if (expq[i].size() == 0) begin
                errors++;
                $display("FAIL %s: pulse at cycle %0d, expected no pulse", nm, cyc);
            end else begin
                e = expq[i].pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL %s: pulse at cycle %0d, expected at cycle %0d", nm, cyc, e);
                end
            end
        end else if (expq[i].size() > 0 && expq[i][0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: no pulse at cycle %0d, expected pulse at cycle %0d", nm, cyc, expq[i][0]);
            void'(expq[i].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            port_chk(0, "a", a);
            port_chk(1, "b", b);
            port_chk(2, "c", c);
            port_chk(3, "d", d);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            pulse_cnt[i] = 0;
            last_cyc[i]  = 0;
        end
    endtask

    task automatic expect_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic expect_quiet(input string nm);
        checks++;
        if ({a, b, c, d} != 4'b0000) begin
            errors++;
            $display("FAIL %s: outputs abcd=%b, required 0000", nm, {a, b, c, d});
        end
    endtask

    int rel;

    initial begin
        tick(2);
        expect_quiet("reset_outputs");
        rst = 1'b1;
        tick(10);

        // bounces then a short press
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            botao = 1'b1; tick(1);
            botao = 1'b0; tick(1);
        end
        botao = 1'b1; tick(8);
        botao = 1'b0; rel = cyc + 1;
        tick(40);
        expect_range("short_b_count", pulse_cnt[1], 1, 1);
        expect_range("short_a_count", pulse_cnt[0], 0, 0);
        expect_range("short_b_latency", last_cyc[1] - rel, 1, 8);

        // long press
        clear_counts();
        botao = 1'b1; tick(60);
        botao = 1'b0; rel = cyc + 1;
        tick(40);
        expect_range("long_a_count", pulse_cnt[0], 1, 1);
        expect_range("long_b_count", pulse_cnt[1], 0, 0);
        expect_range("long_a_during_hold", int'(last_cyc[0] < rel), 1, 1);

        // presence then absence timeout
        clear_counts();
        presenca = 1'b1; tick(10);
        presenca = 1'b0; rel = cyc + 1;
        tick(50);
        expect_range("pres_d_count", pulse_cnt[3], 1, 1);
        expect_range("pres_c_count", pulse_cnt[2], 1, 1);
        expect_range("pres_c_latency", last_cyc[2] - rel, 30, 38);

        // short absence is forgiven, long absence is not
        clear_counts();
        presenca = 1'b1; tick(10);
        presenca = 1'b0; tick(15);
        presenca = 1'b1; tick(10);
        expect_range("brief_absence_c", pulse_cnt[2], 0, 0);
        expect_range("brief_absence_d", pulse_cnt[3], 1, 1);
        presenca = 1'b0; tick(50);
        expect_range("final_absence_c", pulse_cnt[2], 1, 1);
        expect_range("final_absence_d", pulse_cnt[3], 1, 1);

        // reset in the middle of a long press, button kept held
        clear_counts();
        botao = 1'b1;
        tick(int'(DEB) + 3 + 10);
        #1 rst = 1'b0;
        #1 expect_quiet("reset_midpress");
        tick(3);
        rst = 1'b1; rel = cyc + 1;
        clear_counts();
        tick(60);
        botao = 1'b0;
        tick(40);
        expect_range("after_reset_a_count", pulse_cnt[0], 1, 1);
        expect_range("after_reset_b_count", pulse_cnt[1], 0, 0);
        expect_range("after_reset_a_latency", last_cyc[0] - rel, int'(DEB + LONG), 40);

        // single-cycle glitches every third cycle
        clear_counts();
        for (int i = 0; i < 33; i++) begin
            botao = 1'b1; presenca = 1'b1; tick(1);
            botao = 1'b0; presenca = 1'b0; tick(2);
        end
        tick(40);
        expect_range("glitch_a", pulse_cnt[0], 0, 0);
        expect_range("glitch_b", pulse_cnt[1], 0, 0);
        expect_range("glitch_c", pulse_cnt[2], 0, 0);
        expect_range("glitch_d", pulse_cnt[3], 0, 0);

        // random levels and hold lengths, checked only through the scoreboard
        for (int s = 0; s < 60; s++) begin
            botao    = 1'($urandom_range(0, 1));
            presenca = 1'($urandom_range(0, 1));
            tick(int'($urandom_range(1, 70)));
        end
        botao = 1'b0; presenca = 1'b0;
        tick(100);

        expect_range("pending_a", expq[0].size(), 0, 0);
        expect_range("pending_b", expq[1].size(), 0, 0);
        expect_range("pending_c", expq[2].size(), 0, 0);
        expect_range("pending_d", expq[3].size(), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gerador_comandos.md
GERADOR_COMANDOS -- requirements
Module: gerador_comandos

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: consecutive cycles a synchronized input must hold a new level before the debounced level changes.
REQ-002 Parameter LONG_CYCLES, default 1500000: debounced hold length that classifies a button press as long.
REQ-003 Parameter OFF_CYCLES, default 3000000: debounced absence length before the auto-off command is issued.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 botao  in  1  raw push button, active-high, asynchronous to clk, bouncing.
REQ-007 presenca  in  1  raw presence sensor, active-high, asynchronous to clk.
REQ-008 a  out  1  one-cycle pulse: toggle manual/automatic mode (long press).
REQ-009 b  out  1  one-cycle pulse: toggle lamp in manual mode (short press).
REQ-010 c  out  1  one-cycle pulse: auto-off request (absence timeout).
REQ-011 d  out  1  one-cycle pulse: auto-on request (presence detected).

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 The debounced level SHALL update only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any cycle of agreement clears the debounce counter.
REQ-014 Button FSM states: IDLE, PRESSED, LONG_SENT.
REQ-015 IDLE: debounced button 1 -> PRESSED, hold counter cleared.
REQ-016 PRESSED: hold counter increments each cycle; debounced release before the counter reaches LONG_CYCLES -> b pulse, IDLE.
REQ-017 PRESSED: counter reaches LONG_CYCLES while still held -> a pulse, LONG_SENT; no b for that press.
REQ-018 LONG_SENT: debounced release -> IDLE, no pulse; holding indefinitely produces no further pulses.
REQ-019 Presence FSM states: VAZIO, OCUPADO, CONTANDO.
REQ-020 VAZIO: debounced presence 1 -> d pulse, OCUPADO.
REQ-021 OCUPADO: debounced presence 0 -> CONTANDO, absence timer cleared.
REQ-022 CONTANDO: presence 1 -> OCUPADO, timer cleared, no pulse; timer reaches OFF_CYCLES -> c pulse, VAZIO.
REQ-023 All outputs SHALL be registered; each pulse is exactly one cycle wide, asserted the cycle after the FSM transition that causes it.
REQ-024 a and b are never asserted in the same cycle; c and d are never asserted in the same cycle.
REQ-025 A button pulse and a presence pulse MAY coincide; no arbitration is performed here, and the consumer gives a priority over c/d.
REQ-026 Counters SHALL be $clog2(param+1) bits wide and saturate, never wrapping.
REQ-027 Unreachable state encodings SHALL return to IDLE/VAZIO with all outputs 0.

Reset
REQ-028 rst low SHALL immediately force a, b, c, d to 0, both FSMs to IDLE/VAZIO, and all counters, synchronizer flops and debounced levels to 0, independent of clk.
REQ-029 Reset asserted mid-press or mid-timeout SHALL discard that event; no pulse is emitted after deassertion unless a new qualifying event occurs.
REQ-030 An input already high at reset release SHALL be treated as a new rising edge after debounce, giving d for presence and starting a press for the button.

Structure
REQ-031 Button and presence state enums and the default parameter values SHALL live in the shared package pacote_iluminacao.
REQ-032 Synchronizer plus debouncer SHALL be one sub-module, filtro_debounce, with parameter DEB_CYCLES, instantiated twice.

Verification
Use DEB_CYCLES=4, LONG_CYCLES=20, OFF_CYCLES=30 for all directed tests.
REQ-033 Button bounces 3 times, then holds 8 cycles and releases -> exactly one b pulse within 8 cycles of release; a stays 0.
REQ-034 Button held 60 cycles -> exactly one a pulse during the hold, none on release, b stays 0.
REQ-035 Presence rises and holds 10 cycles, then falls -> one d pulse after the rise, then one c pulse 30 to 38 cycles after the fall.
REQ-036 Presence falls for 15 cycles, then returns high -> no c, no second d; falls again and stays low -> one c.
REQ-037 rst pulsed low at hold cycle 10 of a long press, button still held -> outputs 0 at once; after release of rst, a fires only after a fresh 20-cycle debounced hold.
REQ-038 1-cycle glitches on both inputs every 3 cycles for 100 cycles -> no pulse on a, b, c or d.
